// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared 16-bit datapath bus: one-hot
// registered gate enables, a dead turnaround cycle between owners, and a hold-limit watchdog.
module bus_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       bus_busy,
  output logic       timeout
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t          state_r;
  logic [1:0]      owner_r;
  logic [1:0]      last_r;
  logic [CW-1:0]   hold_cnt_r;
  logic [3:0]      grant_r;
  logic            bus_busy_r;
  logic            timeout_r;

  logic [2:0]      pick_s;
  logic            rel_done_s;
  logic            rel_req_s;
  logic            rel_lim_s;
  logic            release_s;

  // Returns {found, index}; the offsets are walked downward so the lowest offset
  // from last+1 wins, leaving index 'base' itself as the lowest priority.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = base + 2'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign pick_s     = rr_pick(req, last_r);
  assign rel_done_s = done[owner_r];
  assign rel_req_s  = ~req[owner_r];
  assign rel_lim_s  = (hold_cnt_r == CW'(HOLD_MAX - 1));
  assign release_s  = rel_done_s | rel_req_s | rel_lim_s;

  // Sequencer: arbitration, hold counting and all registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r    <= ST_IDLE;
      owner_r    <= 2'd0;
      last_r     <= 2'd3;
      hold_cnt_r <= '0;
      grant_r    <= 4'b0000;
      bus_busy_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_TURN: begin
          timeout_r  <= 1'b0;
          hold_cnt_r <= '0;
          if (pick_s[2]) begin
            state_r    <= ST_GRANT;
            owner_r    <= pick_s[1:0];
            last_r     <= pick_s[1:0];
            grant_r    <= 4'b0001 << pick_s[1:0];
            bus_busy_r <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            grant_r    <= 4'b0000;
            bus_busy_r <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            state_r    <= ST_TURN;
            grant_r    <= 4'b0000;
            bus_busy_r <= 1'b0;
            hold_cnt_r <= '0;
            // A concurrent done or dropped request makes this a normal release.
            timeout_r  <= rel_lim_s & ~rel_done_s & ~rel_req_s;
          end else begin
            hold_cnt_r <= hold_cnt_r + CW'(1);
            timeout_r  <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          grant_r    <= 4'b0000;
          bus_busy_r <= 1'b0;
          timeout_r  <= 1'b0;
          hold_cnt_r <= '0;
        end
      endcase
    end
  end

  assign grant      = grant_r;
  assign GatePC     = grant_r[0];
  assign GateMDR    = grant_r[1];
  assign GateALU    = grant_r[2];
  assign GateMARMUX = grant_r[3];
  assign bus_busy   = bus_busy_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed steps push expected outputs,
// a negedge monitor pops and compares; one-hot and turnaround gaps are checked every cycle.
module tb_bus_arbiter;

  logic       Clk;
  logic       Reset_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       bus_busy;
  logic       timeout;

  typedef struct {
    logic [3:0] g;
    logic       b;
    logic       t;
    string      nm;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk;
  int         n_fail;
  logic [3:0] prev_grant;

  bus_arbiter #(.HOLD_MAX(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .done(done), .grant(grant),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .bus_busy(bus_busy), .timeout(timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Monitor: scoreboard compare plus per-cycle structural checks.
  always @(negedge Clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (grant !== e.g || {GateMARMUX, GateALU, GateMDR, GatePC} !== e.g ||
          bus_busy !== e.b || timeout !== e.t) begin
        n_fail++;
        $display("FAIL %s: grant=%b gates=%b busy=%b timeout=%b, expected grant=%b busy=%b timeout=%b",
                 e.nm, grant, {GateMARMUX, GateALU, GateMDR, GatePC}, bus_busy, timeout, e.g, e.b, e.t);
      end
    end
    if (Reset_n) begin
      n_chk++;
      if (!$onehot0(grant)) begin
        n_fail++;
        $display("FAIL onehot: grant=%b, expected at most one bit set", grant);
      end
      n_chk++;
      if (grant != 4'b0000 && prev_grant != 4'b0000 && grant != prev_grant) begin
        n_fail++;
        $display("FAIL turn_gap: grant=%b after %b, expected a zero cycle between owners", grant, prev_grant);
      end
      prev_grant = grant;
    end else begin
      prev_grant = 4'b0000;
    end
  end

  // Drive inputs for one edge and queue the outputs expected after that edge.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] eg,
                      input logic eb, input logic et, input string nm);
    exp_t e;
    req  = r;
    done = d;
    e.g = eg; e.b = eb; e.t = et; e.nm = nm;
    exp_q.push_back(e);
    @(negedge Clk);
    #1;
  endtask

  task automatic check_now(input string nm);
    n_chk++;
    if (grant !== 4'b0000 || {GateMARMUX, GateALU, GateMDR, GatePC} !== 4'b0000 ||
        bus_busy !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: grant=%b gates=%b busy=%b timeout=%b, expected all zero",
               nm, grant, {GateMARMUX, GateALU, GateMDR, GatePC}, bus_busy, timeout);
    end
  endtask

  task automatic do_reset(input string nm);
    Reset_n = 1'b0;
    req     = 4'b0000;
    done    = 4'b0000;
    #1;
    check_now(nm);
    @(negedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    prev_grant = 4'b0000;
    Reset_n = 1'b0;
    req = 4'b0000;
    done = 4'b0000;
    #2;
    check_now("reset_state");
    @(negedge Clk);
    #1;
    Reset_n = 1'b1;

    // Reset and single request
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, "idle_edge1");
    step(4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, "alu_grant");
    step(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, "alu_done");
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, "turn_to_idle");

    // Round robin, all requesting
    do_reset("reset_before_rr");
    step(4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, "rr_pc");
    step(4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0, "rr_turn0");
    step(4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, "rr_mdr");
    step(4'b1111, 4'b0010, 4'b0000, 1'b0, 1'b0, "rr_turn1");
    step(4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b0, "rr_alu");
    step(4'b1111, 4'b0100, 4'b0000, 1'b0, 1'b0, "rr_turn2");
    step(4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, "rr_marmux");
    step(4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b0, "rr_turn3");
    step(4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, "rr_pc_again");
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, "req_drop_release");
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, "turn_to_idle2");

    // Timeout on MDR, then simultaneous done and limit
    step(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, "to_grant");
    step(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, "to_hold1");
    step(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, "to_hold2");
    step(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, "to_hold3");
    step(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, "to_fire");
    step(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, "to_regrant");
    step(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, "lim_hold1");
    step(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, "lim_hold2");
    step(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, "lim_hold3");
    step(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, "done_at_limit");
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, "turn_to_idle3");

    // Non-owner done ignored; hold count keeps running to a timeout
    step(4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, "pc_grant");
    step(4'b0001, 4'b0100, 4'b0001, 1'b1, 1'b0, "alu_done_ignored");
    step(4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, "pc_hold2");
    step(4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, "pc_hold3");
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, "pc_timeout");
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, "turn_to_idle4");
    step(4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, "done_in_idle");

    // Async reset mid-grant
    step(4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b0, "marmux_grant");
    #2;
    Reset_n = 1'b0;
    #1;
    check_now("async_reset_mid_grant");
    @(negedge Clk);
    #1;
    Reset_n = 1'b1;
    step(4'b1001, 4'b0000, 4'b0001, 1'b1, 1'b0, "pc_after_reset");
    step(4'b1001, 4'b0001, 4'b0000, 1'b0, 1'b0, "pc_release");
    step(4'b1001, 4'b0000, 4'b1000, 1'b1, 1'b0, "marmux_next");

    // Random traffic for the structural checks
    exp_q.delete();
    for (int i = 0; i < 1500; i++) begin
      req  = 4'($urandom);
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      @(negedge Clk);
      #1;
    end

    req  = 4'b0000;
    done = 4'b0000;
    repeat (3) @(negedge Clk);
    #1;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
